ssp_host_sched: RTL and testbench
=================================

# ssp_host_sched

Host-side access scheduler for the SSP block. It shares the SSP's single pclk-domain register port (psel/pwrite/pwdata/prdata) between NREQ byte-stream requesters and an RX drain path. Each requester owns a frame-locked round-robin transmit slot. RX reads are issued automatically whenever ssprxintr is raised. Every SSP access is paced so that the SSP's registered FIFO status (ssptxintr/ssprxintr) is always current when an access is decided.

## Interface
- NREQ, 2, number of transmit requesters (2..4)
- GW, $clog2(NREQ) (min 1), width of grant_id
- pclk  in  1  system clock; all logic on rising edge
- clear_b  in  1  synchronous active-low reset
- req_valid  in  NREQ  requester i has a byte on req_data[8i+7:8i]
- req_data  in  8*NREQ  packed requester bytes
- req_last  in  NREQ  byte is last of its frame
- req_ready  out  NREQ  byte of requester i accepted this cycle (combinational, one-hot or zero)
- psel  out  1  SSP select, registered
- pwrite  out  1  1 = write TX FIFO, 0 = read RX FIFO; registered
- pwdata  out  8  write byte to SSP, registered
- prdata  in  8  SSP RX FIFO head, valid during a read access cycle
- ssptxintr  in  1  SSP TX FIFO full
- ssprxintr  in  1  SSP RX FIFO has data to drain
- rx_data  out  8  drained RX byte
- rx_valid  out  1  rx_data holds an unconsumed byte
- rx_ready  in  1  consumer takes rx_data when rx_valid & rx_ready
- grant_id  out  GW  current/last frame owner
- busy  out  1  frame lock held or access on bus

## Operation
- State machine: IDLE (no owner) and FRAME (owner = grant_id locked).
  - IDLE -> FRAME when a write slot is taken by the round-robin winner and its byte is not last.
  - FRAME -> IDLE when the owner's byte with req_last=1 is accepted.
  - A single-byte frame (last on first byte) stays in IDLE.
- Access slot: a decision is made in cycle t only if psel(t)=0. The access appears on the bus in t+1. The bus therefore carries at most one access every 2 cycles.
- Slot priority per decision cycle:
  1. RX read, when ssprxintr=1 and the RX holding register is empty (or being consumed this cycle).
  2. TX write, when ssptxintr=0 and a candidate requester has req_valid=1.
- TX candidate selection:
  - In FRAME, the candidate is only the owner; other requesters wait even if the owner is invalid.
  - In IDLE, the candidate is the first valid requester at or after rr_ptr, cyclically.
- Write accept: req_ready[i]=1 for one cycle. Next cycle psel=1, pwrite=1, pwdata = accepted byte.
- rr_ptr update:
  - Becomes (owner+1) mod NREQ when a frame ends.
  - Single-byte frame in IDLE: rr_ptr becomes winner+1.
- grant_id updates on every accept and holds otherwise.
- Read handling:
  - Next cycle psel=1, pwrite=0, pwdata holds its previous value.
  - prdata is captured at the end of the read cycle. rx_valid=1 the following cycle.
  - rx_valid clears on rx_valid & rx_ready.
  - A read may pre-empt a locked frame's slot; the lock is retained.
- No access is issued while clear_b=0.

## Timing
- Reset values (cycle after clear_b sampled low): psel=0, pwrite=0, pwdata=0x00, req_ready=0, rx_valid=0, rx_data=0x00, grant_id=0, busy=0, rr_ptr=0, state IDLE.
- Reset mid-frame drops the lock. The partially sent frame is not resumed; the requester re-presents it.
- Write latency: accept at t, bus write at t+1. Back-to-back bytes of one frame are accepted at t, t+2, t+4...
- Read latency: decide at t, bus read at t+1, rx_valid=1 at t+2.
- ssptxintr and ssprxintr are sampled only in decision cycles.
  - ssptxintr=1 blocks writes indefinitely; the first write resumes at the first decision cycle with ssptxintr=0.
- RX with rx_valid=1 and rx_ready=0: no further reads are issued; writes continue.
- Simultaneous rx_valid&rx_ready and ssprxintr in a decision cycle: the read is issued (holding register frees that cycle).
- req_ready is never asserted while clear_b=0, while psel=1, or to a non-owner in FRAME.

## Test plan
- Reset: clear_b=0 for 3 cycles with req_valid=2'b11, ssprxintr=1 -> psel=0 and req_ready=0 throughout, all outputs at reset values.
- Single frame: req0 sends 0xAA, 0xF0, 0x55 (last), ssptxintr=0 -> writes with pwdata 0xAA, 0xF0, 0x55 at t+1, t+3, t+5; busy drops after 0x55; rr_ptr=1.
- Round robin, no interleave: req0 frame {0x0F, 0xFF(last)} and req1 frame {0x01, 0x02(last)} both valid from reset -> bus order 0x0F, 0xFF, 0x01, 0x02; grant_id 0,0,1,1.
- TX backpressure: ssptxintr=1 mid-frame for 6 cycles -> no psel and req_ready=0 during that time; first write within 2 cycles of ssptxintr falling; byte order preserved.
- RX drain and priority: ssprxintr=1 during req0 frame, prdata=0x3C -> read access (pwrite=0) takes the next slot, rx_data=0x3C with rx_valid one cycle later; frame resumes with the same owner; with rx_ready=0 no second read until consumed.
- Reset mid-frame: clear_b=0 after the 2nd byte of a 4-byte req1 frame -> state IDLE, grant_id=0; after release, req0 (valid) wins first.

Source files
------------

// File: rtl/ssp_host_sched.sv
// ssp_host_sched: shares the SSP register port between NREQ frame-locked
// round-robin transmit requesters and an automatic RX drain path. Accesses
// are paced one every two cycles so the SSP FIFO status is current when
// each access is decided.
//
// Handshakes: req_valid/req_ready and rx_valid/rx_ready are strict
// valid/ready pairs. A transfer happens in exactly the cycle where both are
// high. A valid source holds its data stable until that cycle, and ready
// never depends on anything the source may change in response to it.
module ssp_host_sched #(
    parameter int NREQ = 2,
    parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              pclk,
    input  logic              clear_b,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              psel,
    output logic              pwrite,
    output logic [7:0]        pwdata,
    input  logic [7:0]        prdata,
    input  logic              ssptxintr,
    input  logic              ssprxintr,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [GW-1:0]     grant_id,
    output logic              busy,
    output logic              state_dbg
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FRAME = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic            psel_q, psel_d;
    logic            pwrite_q, pwrite_d;
    logic [7:0]      pwdata_q, pwdata_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;

    logic            cand_found;
    logic [GW-1:0]   cand_id;
    logic [GW:0]     rot_idx;
    logic            decide;
    logic            rx_free;
    logic            do_read;
    logic            do_write;
    logic [GW-1:0]   next_ptr;

    // Pick the TX candidate: the owner while locked, else the first valid
    // requester at or after rr_ptr (cyclic).
    always_comb begin
        cand_found = 1'b0;
        cand_id    = '0;
        rot_idx    = '0;
        if (state_q == S_FRAME) begin
            cand_found = req_valid[grant_id_q];
            cand_id    = grant_id_q;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                rot_idx = {1'b0, rr_ptr_q} + (GW+1)'(k);
                if (rot_idx >= (GW+1)'(NREQ)) begin
                    rot_idx = rot_idx - (GW+1)'(NREQ);
                end
                if (!cand_found && req_valid[rot_idx[GW-1:0]]) begin
                    cand_found = 1'b1;
                    cand_id    = rot_idx[GW-1:0];
                end
            end
        end
    end

    // Slot decision, FSM next state, bus and RX holding register next values.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        psel_d     = 1'b0;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        req_ready  = '0;

        // A decision needs an idle bus so the FIFO flags reflect the last access.
        decide   = clear_b && !psel_q;
        rx_free  = !rx_valid_q || rx_ready;
        do_read  = decide && ssprxintr && rx_free;
        do_write = decide && !do_read && !ssptxintr && cand_found;
        next_ptr = (cand_id == GW'(NREQ - 1)) ? '0 : cand_id + GW'(1);

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        // The read access cycle ends here; capture the FIFO head.
        if (psel_q && !pwrite_q) begin
            rx_valid_d = 1'b1;
            rx_data_d  = prdata;
        end

        if (do_read) begin
            psel_d   = 1'b1;
            pwrite_d = 1'b0;
        end else if (do_write) begin
            req_ready[cand_id] = 1'b1;
            psel_d     = 1'b1;
            pwrite_d   = 1'b1;
            pwdata_d   = req_data[8*int'(cand_id) +: 8];
            grant_id_d = cand_id;
            if (req_last[cand_id]) begin
                state_d  = S_IDLE;
                rr_ptr_d = next_ptr;
            end else begin
                state_d  = S_FRAME;
            end
        end
    end

    // State registers with synchronous active-low clear.
    always_ff @(posedge pclk) begin
        if (!clear_b) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            psel_q     <= 1'b0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            psel_q     <= psel_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign psel      = psel_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q == S_FRAME) || psel_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ssp_host_sched.sv
// Directed bench for ssp_host_sched with NREQ=2.
module tb_ssp_host_sched;

    logic        pclk;
    logic        clear_b;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        psel;
    logic        pwrite;
    logic [7:0]  pwdata;
    logic [7:0]  prdata;
    logic        ssptxintr;
    logic        ssprxintr;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [0:0]  grant_id;
    logic        busy;
    logic        state_dbg;

    int checks;
    int failures;

    ssp_host_sched #(.NREQ(2)) dut (
        .pclk      (pclk),
        .clear_b   (clear_b),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .psel      (psel),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .ssptxintr (ssptxintr),
        .ssprxintr (ssprxintr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Clock
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Advance one cycle; inputs are then changed 1 time unit after the edge.
    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_check(input string tag, input logic [7:0] data, input logic gid);
        chk({tag, "_psel"}, 32'(psel), 32'd1);
        chk({tag, "_pwrite"}, 32'(pwrite), 32'd1);
        chk({tag, "_pwdata"}, 32'(pwdata), 32'(data));
        chk({tag, "_grant"}, 32'(grant_id), 32'(gid));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        clear_b   = 1'b0;
        req_valid = 2'b11;
        req_data  = {8'h01, 8'h0F};
        req_last  = 2'b00;
        prdata    = 8'h00;
        ssptxintr = 1'b0;
        ssprxintr = 1'b1;
        rx_ready  = 1'b0;

        // ---- Reset held 3 cycles with requests and RX pending ----
        for (int i = 0; i < 3; i++) begin
            cyc();
            settle();
            chk("rst_psel", 32'(psel), 32'd0);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
        end
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_pwdata", 32'(pwdata), 32'h00);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);

        // ---- Single frame from req0: AA, F0, 55(last) ----
        clear_b   = 1'b1;
        ssprxintr = 1'b0;
        req_valid = 2'b01;
        req_data  = {8'h00, 8'hAA};
        req_last  = 2'b00;
        settle();
        chk("sf_ready0", 32'(req_ready), 32'b01);
        cyc();
        wr_check("sf_w0", 8'hAA, 1'b0);
        chk("sf_state", 32'(state_dbg), 32'd1);
        req_data = {8'h00, 8'hF0};
        settle();
        chk("sf_ready_psel", 32'(req_ready), 32'b00);
        cyc();
        chk("sf_gap_psel", 32'(psel), 32'd0);
        chk("sf_busy_gap", 32'(busy), 32'd1);
        chk("sf_ready1", 32'(req_ready), 32'b01);
        cyc();
        wr_check("sf_w1", 8'hF0, 1'b0);
        req_data = {8'h00, 8'h55};
        req_last = 2'b01;
        cyc();
        settle();
        chk("sf_ready2", 32'(req_ready), 32'b01);
        cyc();
        wr_check("sf_w2", 8'h55, 1'b0);
        chk("sf_state_end", 32'(state_dbg), 32'd0);
        req_valid = 2'b00;
        req_last  = 2'b00;
        cyc();
        chk("sf_busy_end", 32'(busy), 32'd0);

        // ---- rr_ptr=1 now: req1 wins; single-byte frames stay IDLE ----
        req_valid = 2'b11;
        req_data  = {8'h77, 8'h11};
        req_last  = 2'b11;
        settle();
        chk("rr_ready_req1", 32'(req_ready), 32'b10);
        cyc();
        wr_check("rr_w77", 8'h77, 1'b1);
        chk("rr_state_single", 32'(state_dbg), 32'd0);
        req_valid = 2'b01;
        cyc();
        settle();
        chk("rr_ready_req0", 32'(req_ready), 32'b01);
        cyc();
        wr_check("rr_w11", 8'h11, 1'b0);
        req_valid = 2'b00;
        req_last  = 2'b00;

        // ---- Reset pulse, then round robin without interleave ----
        clear_b = 1'b0;
        cyc();
        clear_b   = 1'b1;
        req_valid = 2'b11;
        req_data  = {8'h01, 8'h0F};
        req_last  = 2'b00;
        settle();
        chk("rr2_ready_first", 32'(req_ready), 32'b01);
        cyc();
        wr_check("rr2_w0F", 8'h0F, 1'b0);
        // owner momentarily invalid: req1 must still wait
        req_valid = 2'b10;
        req_data  = {8'h01, 8'hFF};
        req_last  = 2'b01;
        cyc();
        settle();
        chk("rr2_nonowner_blocked", 32'(req_ready), 32'b00);
        req_valid = 2'b11;
        settle();
        chk("rr2_ready_owner", 32'(req_ready), 32'b01);
        cyc();
        wr_check("rr2_wFF", 8'hFF, 1'b0);
        req_valid = 2'b10;
        req_last  = 2'b00;
        cyc();
        settle();
        chk("rr2_ready_req1", 32'(req_ready), 32'b10);
        cyc();
        wr_check("rr2_w01", 8'h01, 1'b1);
        req_data = {8'h02, 8'h00};
        req_last = 2'b10;
        cyc();
        settle();
        chk("rr2_ready_req1b", 32'(req_ready), 32'b10);
        cyc();
        wr_check("rr2_w02", 8'h02, 1'b1);
        req_valid = 2'b00;
        req_last  = 2'b00;
        cyc();

        // ---- TX backpressure mid-frame (rr_ptr=0) ----
        req_valid = 2'b01;
        req_data  = {8'h00, 8'hA1};
        settle();
        chk("bp_ready0", 32'(req_ready), 32'b01);
        cyc();
        wr_check("bp_wA1", 8'hA1, 1'b0);
        req_data  = {8'h00, 8'hA2};
        ssptxintr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            settle();
            chk("bp_hold_psel", 32'(psel), 32'd0);
            chk("bp_hold_ready", 32'(req_ready), 32'b00);
        end
        ssptxintr = 1'b0;
        settle();
        chk("bp_resume_ready", 32'(req_ready), 32'b01);
        cyc();
        wr_check("bp_wA2", 8'hA2, 1'b0);
        req_data = {8'h00, 8'hA3};
        req_last = 2'b01;
        cyc();
        settle();
        chk("bp_ready2", 32'(req_ready), 32'b01);
        cyc();
        wr_check("bp_wA3", 8'hA3, 1'b0);
        req_valid = 2'b00;
        req_last  = 2'b00;
        cyc();

        // ---- RX drain pre-empts a locked frame (rr_ptr=1, only req0) ----
        req_valid = 2'b01;
        req_data  = {8'h00, 8'hC1};
        settle();
        chk("rx_ready_c1", 32'(req_ready), 32'b01);
        cyc();
        wr_check("rx_wC1", 8'hC1, 1'b0);
        ssprxintr = 1'b1;
        prdata    = 8'h3C;
        rx_ready  = 1'b0;
        req_data  = {8'h00, 8'hC2};
        req_last  = 2'b01;
        cyc();
        settle();
        chk("rx_read_preempts", 32'(req_ready), 32'b00);
        cyc();
        chk("rx_rd_psel", 32'(psel), 32'd1);
        chk("rx_rd_pwrite", 32'(pwrite), 32'd0);
        chk("rx_rd_pwdata_hold", 32'(pwdata), 32'hC1);
        chk("rx_rd_lock_kept", 32'(state_dbg), 32'd1);
        cyc();
        settle();
        chk("rx_valid_set", 32'(rx_valid), 32'd1);
        chk("rx_data_3c", 32'(rx_data), 32'h3C);
        chk("rx_frame_resumes", 32'(req_ready), 32'b01);
        cyc();
        wr_check("rx_wC2", 8'hC2, 1'b0);
        req_valid = 2'b00;
        req_last  = 2'b00;
        cyc();
        cyc();
        chk("rx_no_2nd_read", 32'(psel), 32'd0);
        chk("rx_still_held", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        prdata   = 8'h5A;
        cyc();
        chk("rx_rd2_psel", 32'(psel), 32'd1);
        chk("rx_rd2_pwrite", 32'(pwrite), 32'd0);
        chk("rx_consumed", 32'(rx_valid), 32'd0);
        rx_ready  = 1'b0;
        ssprxintr = 1'b0;
        cyc();
        chk("rx2_valid", 32'(rx_valid), 32'd1);
        chk("rx2_data", 32'(rx_data), 32'h5A);
        rx_ready = 1'b1;
        cyc();
        chk("rx2_consumed", 32'(rx_valid), 32'd0);
        rx_ready = 1'b0;

        // ---- Reset mid-frame of a 4-byte req1 frame (rr_ptr=1) ----
        req_valid = 2'b10;
        req_data  = {8'hD1, 8'h00};
        settle();
        chk("mr_ready_d1", 32'(req_ready), 32'b10);
        cyc();
        wr_check("mr_wD1", 8'hD1, 1'b1);
        req_data = {8'hD2, 8'h00};
        cyc();
        settle();
        chk("mr_ready_d2", 32'(req_ready), 32'b10);
        cyc();
        wr_check("mr_wD2", 8'hD2, 1'b1);
        clear_b   = 1'b0;
        req_valid = 2'b11;
        req_data  = {8'hD3, 8'hB0};
        req_last  = 2'b01;
        settle();
        chk("mr_ready_in_rst", 32'(req_ready), 32'b00);
        cyc();
        settle();
        chk("mr_state", 32'(state_dbg), 32'd0);
        chk("mr_grant", 32'(grant_id), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_ready_rst", 32'(req_ready), 32'b00);
        clear_b = 1'b1;
        settle();
        chk("mr_req0_wins", 32'(req_ready), 32'b01);
        cyc();
        wr_check("mr_wB0", 8'hB0, 1'b0);
        req_valid = 2'b00;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
